// File: rtl/cls_pwm_interval_tick_gen.sv
// PWM interval tick generator: emits a one-cycle tick at the start of every
// PWM period and supports glitch-free runtime period changes via a
// request/busy/done handshake applied only on period boundaries.
module cls_pwm_interval_tick_gen #(
  parameter int unsigned CLK_RATE_HZ  = 50000000,
  parameter int unsigned DUTY_RATE_HZ = 1000,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned DEFAULT_DIV  = CLK_RATE_HZ / DUTY_RATE_HZ
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic                 SYNC,
  input  logic [DIV_WIDTH-1:0] RATE_DIV,
  input  logic                 RATE_LOAD_REQ,
  output logic                 RATE_LOAD_BUSY,
  output logic                 RATE_LOAD_DONE,
  output logic                 PWM_INTERVAL_TICK,
  output logic [2:0]           TICK_INDEX
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

  typedef enum logic {
    LD_IDLE,
    LD_PENDING
  } ld_state_e;

  ld_state_e            ld_state_q, ld_state_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] active_q, active_d;
  logic [DIV_WIDTH-1:0] pending_q, pending_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic [2:0]           idx_q, idx_d;

  logic                 terminal;
  logic                 reload;
  logic                 apply;
  logic                 accept;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] reload_val;

  // Boundary detection and handshake qualifiers shared by all next-state logic
  always_comb begin
    terminal    = (count_q == '0);
    // A disabled cycle counts as a boundary so a pending divisor lands at once
    reload      = !ENABLE || SYNC || terminal;
    apply       = (ld_state_q == LD_PENDING) && reload;
    accept      = RATE_LOAD_REQ && (ld_state_q == LD_IDLE);
    div_clamped = (RATE_DIV < TWO) ? TWO : RATE_DIV;
    reload_val  = apply ? (pending_q - ONE) : (active_q - ONE);
  end

  // Load-handshake state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ld_state_q <= LD_IDLE;
    end else begin
      ld_state_q <= ld_state_d;
    end
  end

  // Load-handshake next state: capture on accepted request, release on apply
  always_comb begin
    ld_state_d = ld_state_q;
    unique case (ld_state_q)
      LD_IDLE:    if (accept) ld_state_d = LD_PENDING;
      LD_PENDING: if (apply)  ld_state_d = LD_IDLE;
      default:    ld_state_d = LD_IDLE;
    endcase
  end

  // Load-handshake outputs
  always_comb begin
    RATE_LOAD_BUSY = (ld_state_q == LD_PENDING);
  end

  // Counter, divisor and tick next-state
  always_comb begin
    count_d   = reload ? reload_val : (count_q - ONE);
    active_d  = apply ? pending_q : active_q;
    pending_d = accept ? div_clamped : pending_q;
    // SYNC suppresses the terminal tick of the period it restarts
    tick_d    = ENABLE && !SYNC && terminal;
    done_d    = apply;
    idx_d     = tick_d ? (idx_q + 3'd1) : idx_q;
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q   <= DEF_DIV - ONE;
      active_q  <= DEF_DIV;
      pending_q <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
    end
  end

  assign RATE_LOAD_DONE    = done_q;
  assign PWM_INTERVAL_TICK = tick_q;
  assign TICK_INDEX        = idx_q;

endmodule

// File: tb/tb_cls_pwm_interval_tick_gen.sv
// Self-checking bench for cls_pwm_interval_tick_gen: directed scenarios and
// random stimulus compared against a period/phase behavioural model.
module tb_cls_pwm_interval_tick_gen;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEF = 10;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          ENABLE;
  logic          SYNC;
  logic [DW-1:0] RATE_DIV;
  logic          RATE_LOAD_REQ;
  logic          RATE_LOAD_BUSY;
  logic          RATE_LOAD_DONE;
  logic          PWM_INTERVAL_TICK;
  logic [2:0]    TICK_INDEX;

  cls_pwm_interval_tick_gen #(
    .CLK_RATE_HZ (1000),
    .DUTY_RATE_HZ(100),
    .DIV_WIDTH   (DW)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .ENABLE           (ENABLE),
    .SYNC             (SYNC),
    .RATE_DIV         (RATE_DIV),
    .RATE_LOAD_REQ    (RATE_LOAD_REQ),
    .RATE_LOAD_BUSY   (RATE_LOAD_BUSY),
    .RATE_LOAD_DONE   (RATE_LOAD_DONE),
    .PWM_INTERVAL_TICK(PWM_INTERVAL_TICK),
    .TICK_INDEX       (TICK_INDEX)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model: period length, phase within period (counting up),
  // pending divisor, tick count
  int unsigned m_period, m_phase, m_pend, m_idx;
  bit          m_pv, e_tick, e_done, prev_tick;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_period  = DEF;
    m_phase   = 0;
    m_pend    = 0;
    m_pv      = 0;
    m_idx     = 0;
    e_tick    = 0;
    e_done    = 0;
    prev_tick = 0;
  endtask

  // One clock: drive inputs, advance the model, compare every output
  task automatic step(input bit en, input bit sy, input bit rq, input int unsigned dv);
    bit last, bound;
    ENABLE        = en;
    SYNC          = sy;
    RATE_LOAD_REQ = rq;
    RATE_DIV      = DW'(dv);
    @(posedge CLK);
    last   = (m_phase == m_period - 1);
    bound  = !en || sy || last;
    e_tick = en && !sy && last;
    e_done = m_pv && bound;
    if (e_done) begin
      m_period = m_pend;
      m_pv     = 0;
    end else if (rq && !m_pv) begin
      m_pend = (dv < 2) ? 2 : dv;
      m_pv   = 1;
    end
    m_phase = (en && !bound) ? m_phase + 1 : 0;
    if (e_tick) m_idx = (m_idx + 1) % 8;
    #1;
    chk("tick", PWM_INTERVAL_TICK, e_tick);
    chk("done", RATE_LOAD_DONE, e_done);
    chk("busy", RATE_LOAD_BUSY, m_pv);
    chk("index", TICK_INDEX, m_idx);
    if (prev_tick) chk("tick_double", PWM_INTERVAL_TICK, 0);
    prev_tick = PWM_INTERVAL_TICK;
    @(negedge CLK);
  endtask

  // Enabled idle clocks until the DUT ticks; n = clocks taken
  task automatic wait_tick(output int unsigned n);
    n = 0;
    do begin
      step(1, 0, 0, 0);
      n++;
    end while (!PWM_INTERVAL_TICK && n < 200);
    if (n >= 200) chk("tick_timeout", n, 0);
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_tick", PWM_INTERVAL_TICK, 0);
    chk("rst_done", RATE_LOAD_DONE, 0);
    chk("rst_busy", RATE_LOAD_BUSY, 0);
    chk("rst_index", TICK_INDEX, 0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    int unsigned n;
    RESET_N = 1'b0;
    ENABLE = 0; SYNC = 0; RATE_LOAD_REQ = 0; RATE_DIV = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_tick", PWM_INTERVAL_TICK, 0);
    chk("reset_index", TICK_INDEX, 0);
    chk("reset_busy", RATE_LOAD_BUSY, 0);
    chk("reset_done", RATE_LOAD_DONE, 0);
    RESET_N = 1'b1;

    // 1: default spacing and index progression
    wait_tick(n); chk("first_tick", n, DEF);
    chk("idx_first", TICK_INDEX, 1);
    for (int i = 2; i <= 8; i++) begin
      wait_tick(n);
      chk("spacing_default", n, DEF);
      chk("idx_seq", TICK_INDEX, i % 8);
    end

    // 2: load 4, requested 3 clocks after a tick
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 4);
    step(1, 0, 0, 0);
    chk("busy_after_req", RATE_LOAD_BUSY, 1);
    wait_tick(n); chk("old_period_done", n, DEF - 4);
    chk("done_with_tick", RATE_LOAD_DONE, 1);
    wait_tick(n); chk("spacing_4", n, 4);
    chk("busy_cleared", RATE_LOAD_BUSY, 0);

    // 3: divisors 1 and 0 clamp to 2
    step(1, 0, 1, 1);
    wait_tick(n); wait_tick(n); wait_tick(n); chk("clamp_1", n, 2);
    step(1, 0, 1, 0);
    wait_tick(n); wait_tick(n); wait_tick(n); chk("clamp_0", n, 2);

    // back to 10 for the SYNC scenario
    step(1, 0, 1, 10);
    wait_tick(n); wait_tick(n); chk("spacing_10", n, DEF);

    // 4: SYNC on the terminal cycle, then REQ while busy is ignored
    n = 0;
    while (m_phase != m_period - 1 && n < 50) begin
      step(1, 0, 0, 0);
      n++;
    end
    step(1, 1, 0, 0);
    chk("sync_suppress", PWM_INTERVAL_TICK, 0);
    step(1, 0, 1, 5);
    step(1, 0, 1, 7);
    wait_tick(n); chk("after_sync", n, DEF - 2);
    wait_tick(n); chk("first_req_wins", n, 5);

    // 5: drop ENABLE with 6 pending
    step(1, 0, 1, 6);
    step(0, 0, 0, 0);
    chk("done_disabled", RATE_LOAD_DONE, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    wait_tick(n); chk("enable_rise", n, 6);

    // 6: reset mid-period with a divisor pending
    step(1, 0, 1, 3);
    step(1, 0, 0, 0);
    apply_reset();
    wait_tick(n); chk("post_reset", n, DEF);
    chk("post_reset_busy", RATE_LOAD_BUSY, 0);

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
